// File: rtl/regfile_mp_if.sv
// Bus bundle for the regfile_mp GPR file: two read ports, one write port,
// interrupt cause inputs and the bulk-clear request/busy pair.
interface regfile_mp_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_IRQ = 1
);
    logic [ADDR_W-1:0]  addr1;
    logic [DATA_W-1:0]  data1;
    logic [ADDR_W-1:0]  addr2;
    logic [DATA_W-1:0]  data2;
    logic               wr;
    logic [ADDR_W-1:0]  addr3;
    logic [DATA_W-1:0]  data3;
    logic [NUM_IRQ-1:0] irq;
    logic               clr_req;
    logic               busy;

    modport master (
        output addr1, addr2, wr, addr3, data3, irq, clr_req,
        input  data1, data2, busy
    );

    modport slave (
        input  addr1, addr2, wr, addr3, data3, irq, clr_req,
        output data1, data2, busy
    );
endinterface

// File: rtl/regfile_mp.sv
// 1-write/2-read GPR file with sticky interrupt-cause capture and a sequenced bulk clear.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_IRQ   = 1,
    parameter int CAUSE_REG = 27
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    // state | meaning
    // IDLE  | normal operation, writes accepted, busy=0
    // CLEAR | zeroing one register per cycle from idx 1 up to NREG-1, busy=1
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam int NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREG-1);
    localparam logic [ADDR_W-1:0] CAUSE_IDX = ADDR_W'(CAUSE_REG);

    state_t             state_q;
    logic               busy_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [DATA_W-1:0]  rf_q [NREG];

    logic               wr_fire;
    logic [DATA_W-1:0]  irq_ext;
    logic [DATA_W-1:0]  cause_d;
    logic [DATA_W-1:0]  rd1_d;
    logic [DATA_W-1:0]  rd2_d;

    always_comb begin
        irq_ext = '0;
        irq_ext[NUM_IRQ-1:0] = bus.irq;
    end

    assign wr_fire = bus.wr && (bus.addr3 != '0) && (state_q == IDLE);

    // Cause register sees write/clear first, then irq sets on top so a set always wins.
    always_comb begin
        cause_d = rf_q[CAUSE_IDX];
        if (wr_fire && (bus.addr3 == CAUSE_IDX)) begin
            cause_d = bus.data3;
        end
        if ((state_q == CLEAR) && (idx_q == CAUSE_IDX)) begin
            cause_d = '0;
        end
        cause_d = cause_d | irq_ext;
    end

    always_comb begin
        rd1_d = (bus.addr1 == '0) ? '0 : rf_q[bus.addr1];
        rd2_d = (bus.addr2 == '0) ? '0 : rf_q[bus.addr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_fire && (bus.addr1 == bus.addr3)) begin
            rd1_d = (bus.addr3 == CAUSE_IDX) ? (bus.data3 | irq_ext) : bus.data3;
        end
        if (wr_fire && (bus.addr2 == bus.addr3)) begin
            rd2_d = (bus.addr3 == CAUSE_IDX) ? (bus.data3 | irq_ext) : bus.data3;
        end
`endif
    end

    assign bus.data1 = rd1_d;
    assign bus.data2 = rd2_d;
    assign bus.busy  = busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            idx_q   <= ADDR_W'(1);
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_fire) begin
                        rf_q[bus.addr3] <= bus.data3;
                    end
                    if (bus.clr_req) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        idx_q   <= ADDR_W'(1);
                    end
                end
                CLEAR: begin
                    rf_q[idx_q] <= '0;
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        idx_q   <= ADDR_W'(1);
                    end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    idx_q   <= ADDR_W'(1);
                end
            endcase
            rf_q[CAUSE_IDX] <= cause_d;
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed scenarios plus random traffic checked
// against an array-based reference model.
module tb_regfile_mp;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int NUM_IRQ   = 1;
    localparam int CAUSE_REG = 27;
    localparam int NREG      = 2**ADDR_W;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_IRQ(NUM_IRQ)) bus ();

    regfile_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_IRQ(NUM_IRQ), .CAUSE_REG(CAUSE_REG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic              busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: array of register values plus clear progress.
    logic [DATA_W-1:0] m_rf [NREG];
    bit                m_busy;
    int                m_next_clr;

    function automatic logic [DATA_W-1:0] irq_word(input logic [NUM_IRQ-1:0] irq);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < NUM_IRQ; i++) w[i] = irq[i];
        return w;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) m_rf[i] = '0;
        m_busy     = 0;
        m_next_clr = 1;
    endfunction

    function automatic void model_tick();
        int a3;
        if (!reset) return;
        a3 = int'(bus.addr3);
        if (!m_busy) begin
            if (bus.wr && a3 != 0) m_rf[a3] = bus.data3;
            if (bus.clr_req) begin
                m_busy     = 1;
                m_next_clr = 1;
            end
        end else begin
            m_rf[m_next_clr] = '0;
            m_next_clr++;
            if (m_next_clr == NREG) m_busy = 0;
        end
        m_rf[CAUSE_REG] = m_rf[CAUSE_REG] | irq_word(bus.irq);
    endfunction

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        if (a == '0) return '0;
        v = m_rf[int'(a)];
`ifdef REGFILE_BYPASS_EN
        if (bus.wr && bus.addr3 != '0 && !m_busy && a == bus.addr3) begin
            v = (int'(a) == CAUSE_REG) ? (bus.data3 | irq_word(bus.irq)) : bus.data3;
        end
`endif
        return v;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.a1   = bus.addr1;
        e.a2   = bus.addr2;
        e.d1   = model_read(bus.addr1);
        e.d2   = model_read(bus.addr2);
        e.busy = m_busy;
        sb_q.push_back(e);
    endfunction

    task automatic drive(input logic wr, input logic [ADDR_W-1:0] a3, input logic [DATA_W-1:0] d3,
                         input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                         input logic [NUM_IRQ-1:0] irq, input logic clr);
        bus.wr      = wr;
        bus.addr3   = a3;
        bus.data3   = d3;
        bus.addr1   = a1;
        bus.addr2   = a2;
        bus.irq     = irq;
        bus.clr_req = clr;
    endtask

    task automatic step(input logic wr, input logic [ADDR_W-1:0] a3, input logic [DATA_W-1:0] d3,
                        input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                        input logic [NUM_IRQ-1:0] irq, input logic clr);
        @(posedge clk);
        model_tick();
        #1;
        drive(wr, a3, d3, a1, a2, irq, clr);
        push_exp();
    endtask

    // Monitor: outputs are combinational, so every cycle presents one response.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (bus.data1 !== e.d1 || bus.data2 !== e.d2 || bus.busy !== e.busy) begin
                n_err++;
                $display("FAIL read a1=%0d a2=%0d: got d1=%h d2=%h busy=%b, want d1=%h d2=%h busy=%b",
                         e.a1, e.a2, bus.data1, bus.data2, bus.busy, e.d1, e.d2, e.busy);
            end
        end
    end

    localparam logic [ADDR_W-1:0]  A0 = '0;
    localparam logic [ADDR_W-1:0]  AC = ADDR_W'(CAUSE_REG);
    localparam logic [NUM_IRQ-1:0] I0 = '0;
    localparam logic [NUM_IRQ-1:0] I1 = NUM_IRQ'(1);

    initial begin
        int busy_cnt;
        logic [ADDR_W-1:0] ra, rb, wa;
        logic [DATA_W-1:0] wd;
        logic [NUM_IRQ-1:0] ri;

        model_reset();
        drive(1'b0, A0, '0, A0, A0, I0, 1'b0);
        repeat (2) step(1'b0, A0, '0, ADDR_W'(3), AC, I0, 1'b0);
        @(posedge clk);
        model_tick();
        #1 reset = 1'b1;
        drive(1'b0, A0, '0, A0, A0, I0, 1'b0);
        push_exp();

        // Write to r0 is dropped
        step(1'b1, A0, 32'hFFFF_FFFF, A0, A0, I0, 1'b0);
        step(1'b0, A0, '0, A0, A0, I0, 1'b0);

        // Write r9 with same-cycle read, then read next cycle
        step(1'b1, ADDR_W'(9), 32'hDEAD_BEEF, ADDR_W'(9), ADDR_W'(9), I0, 1'b0);
        step(1'b0, A0, '0, ADDR_W'(9), A0, I0, 1'b0);

        // Sticky cause bit behaviour
        step(1'b0, A0, '0, AC, A0, I1, 1'b0);
        step(1'b0, A0, '0, AC, A0, I0, 1'b0);
        step(1'b1, AC, '0, AC, AC, I1, 1'b0);
        step(1'b0, A0, '0, AC, A0, I0, 1'b0);
        step(1'b1, AC, '0, AC, AC, I0, 1'b0);
        step(1'b0, A0, '0, AC, A0, I0, 1'b0);

        // Fill with index, bulk clear with irq held, writes to r3 during busy
        for (int i = 1; i < NREG; i++) step(1'b1, ADDR_W'(i), DATA_W'(i), ADDR_W'(i), ADDR_W'(i-1), I0, 1'b0);
        step(1'b0, A0, '0, ADDR_W'(3), AC, I1, 1'b1);
        busy_cnt = 0;
        for (int k = 0; k < NREG + 8; k++) begin
            step(1'b1, ADDR_W'(3), 32'h1234_5678, ADDR_W'(3), ADDR_W'(k % NREG), I1, 1'b0);
            #4;
            if (bus.busy === 1'b1) busy_cnt++;
            else if (busy_cnt > 0) break;
        end
        n_vec++;
        if (busy_cnt != NREG - 1) begin
            n_err++;
            $display("FAIL clear_duration: got %0d busy cycles, want %0d", busy_cnt, NREG - 1);
        end
        for (int i = 0; i < NREG; i += 2) step(1'b0, A0, '0, ADDR_W'(i), ADDR_W'(i+1), I1, 1'b0);
        step(1'b0, A0, '0, AC, A0, I0, 1'b0);

        // Reset asserted in the middle of a clear
        step(1'b1, ADDR_W'(5), 32'hA5A5_0005, ADDR_W'(5), AC, I0, 1'b0);
        step(1'b1, AC, 32'h5A5A_0027, ADDR_W'(5), AC, I0, 1'b0);
        step(1'b0, A0, '0, ADDR_W'(5), AC, I0, 1'b1);
        repeat (3) step(1'b0, A0, '0, ADDR_W'(5), AC, I0, 1'b0);
        @(posedge clk);
        model_tick();
        #2 reset = 1'b0;
        model_reset();
        drive(1'b0, A0, '0, ADDR_W'(5), AC, I0, 1'b0);
        push_exp();
        for (int i = 0; i < NREG; i += 2) step(1'b0, A0, '0, ADDR_W'(i), ADDR_W'(i+1), I0, 1'b0);
        @(posedge clk);
        model_tick();
        #1 reset = 1'b1;
        drive(1'b0, A0, '0, ADDR_W'(5), AC, I0, 1'b0);
        push_exp();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            wa = ($urandom_range(0, 7) == 0) ? AC : ADDR_W'($urandom);
            wd = ($urandom_range(0, 5) == 0) ? '0 : DATA_W'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? AC : ADDR_W'($urandom);
            ri = ($urandom_range(0, 5) == 0) ? NUM_IRQ'($urandom) : I0;
            step(1'($urandom), wa, wd, ra, rb, ri, ($urandom_range(0, 59) == 0));
        end
        step(1'b0, A0, '0, A0, A0, I0, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
